// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle over WIDTH/DIGIT cycles,
// then presents sum, carry-out and signed overflow for one DONE cycle and holds them.
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, sr, next_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry, dc_msb, rc, last;

  // Ripple across the digit; dc_msb keeps the carry into the digit's top bit for ovf.
  always_comb begin
    dsum   = '0;
    rc     = carry;
    dc_msb = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dc_msb  = rc;
      dsum[i] = a_reg[i] ^ b_reg[i] ^ rc;
      rc      = (a_reg[i] & b_reg[i]) | (rc & (a_reg[i] ^ b_reg[i]));
    end
    dcarry  = rc;
    next_sr = (sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      carry <= dcarry;
      cnt   <= cnt + CW'(1);
      sr    <= next_sr;
      if (last) begin
        sum   <= next_sr;
        c_out <= dcarry;
        ovf   <= dcarry ^ dc_msb;
      end
    end else if (start) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : c_in;
      cnt   <= '0;
      sr    <= '0;
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboarded bench: directed vectors on an 8/2 instance plus model-checked random
// traffic on 8/8 and 16/4 instances; monitors pop expectations on each done pulse.
module tb_serial_digit_adder;

  typedef struct {
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  exp_t q0[$], q1[$], q2[$];

  // Instance 0: WIDTH=8, DIGIT=2 (N=4)
  logic       rst0 = 1'b1, start0 = 1'b0, sub0 = 1'b0, cin0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, sum0;
  logic       busy0, done0, co0, ov0;
  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .sub(sub0), .a(a0), .b(b0), .c_in(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(co0), .ovf(ov0));

  // Instance 1: WIDTH=8, DIGIT=8 (N=1)
  logic       rst_r = 1'b1;
  logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, co1, ov1;
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u1 (
    .clk(clk), .rst(rst_r), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1), .ovf(ov1));

  // Instance 2: WIDTH=16, DIGIT=4 (N=4)
  logic        start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0, sum2;
  logic        busy2, done2, co2, ov2;
  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst_r), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(co2), .ovf(ov2));

  function automatic exp_t mk(logic [15:0] s, logic co, logic ov, int unsigned c);
    exp_t e;
    e.sum = s; e.c_out = co; e.ovf = ov; e.cyc = c;
    return e;
  endfunction

  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic s, logic ci,
                                 int unsigned c);
    exp_t        e;
    logic [15:0] mask, bb;
    logic [16:0] full;
    mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
    bb    = s ? (~b & mask) : (b & mask);
    full  = {1'b0, a & mask} + {1'b0, bb} + {16'h0, (s ? 1'b1 : ci)};
    e.sum = full[15:0] & mask;
    e.c_out = full[w];
    if (s) e.ovf = (a[w-1] != b[w-1]) && (e.sum[w-1] != a[w-1]);
    else   e.ovf = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.cyc = c;
    return e;
  endfunction

  task automatic check(string nm, exp_t e, logic [15:0] s, logic co, logic ov);
    compared++;
    if (s !== e.sum || co !== e.c_out || ov !== e.ovf || cyc != e.cyc) begin
      mismatched++;
      $display("FAIL %s: got sum=%h c_out=%b ovf=%b cyc=%0d, want sum=%h c_out=%b ovf=%b cyc=%0d",
               nm, s, co, ov, cyc, e.sum, e.c_out, e.ovf, e.cyc);
    end
  endtask

  task automatic unexpected(string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: done pulse with no pending operation at cyc=%0d", nm, cyc);
  endtask

  // Monitors sample #1 after the edge; drivers act on the falling edge.
  logic [9:0] held0 = '0;
  always @(posedge clk) begin
    #1;
    if (done0) begin
      if (q0.size() == 0) unexpected("main");
      else check("main", q0.pop_front(), {8'h00, sum0}, co0, ov0);
    end
    if (busy0) begin
      compared++;
      if ({sum0, co0, ov0} !== held0) begin
        mismatched++;
        $display("FAIL hold: got %h, want %h during busy", {sum0, co0, ov0}, held0);
      end
    end else held0 = {sum0, co0, ov0};
  end

  always @(posedge clk) begin
    #1;
    if (done1) begin
      if (q1.size() == 0) unexpected("w8d8");
      else check("w8d8", q1.pop_front(), {8'h00, sum1}, co1, ov1);
    end
  end

  always @(posedge clk) begin
    #1;
    if (done2) begin
      if (q2.size() == 0) unexpected("w16d4");
      else check("w16d4", q2.pop_front(), sum2, co2, ov2);
    end
  end

  task automatic wait_idle0();
    int unsigned k = 0;
    while (busy0 && k < 100) begin @(negedge clk); k++; end
    if (busy0) begin
      compared++; mismatched++;
      $display("FAIL idle0: busy=%b, want 0 within 100 cycles", busy0);
    end
  endtask

  task automatic issue0(logic [7:0] a, logic [7:0] b, logic s, logic ci,
                        logic [7:0] es, logic eco, logic eov);
    wait_idle0();
    a0 = a; b0 = b; sub0 = s; cin0 = ci; start0 = 1'b1;
    q0.push_back(mk({8'h00, es}, eco, eov, cyc + 5));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic main_seq();
    compared++;
    if ({busy0, done0, sum0, co0, ov0} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset: got busy/done/sum/c/v=%h, want 000", {busy0, done0, sum0, co0, ov0});
    end
    rst0 = 1'b0;
    @(negedge clk);
    issue0(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    issue0(8'h0F, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    issue0(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    issue0(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    issue0(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    issue0(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    issue0(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    issue0(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h97, 1'b0, 1'b1);
    issue0(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // start held high across RUN with churning operands, then accepted again in DONE
    wait_idle0();
    a0 = 8'h12; b0 = 8'h34; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
    q0.push_back(mk(16'h0046, 1'b0, 1'b0, cyc + 5));
    repeat (4) begin
      @(negedge clk);
      a0 = 8'($urandom); b0 = 8'($urandom);
      sub0 = 1'($urandom_range(0, 1)); cin0 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a0 = 8'hC8; b0 = 8'h50; sub0 = 1'b1; cin0 = 1'b0;
    q0.push_back(mk(16'h0078, 1'b1, 1'b1, cyc + 5));
    @(negedge clk);
    start0 = 1'b0;

    // abort in the second busy cycle: outputs clear, no done
    wait_idle0();
    @(negedge clk);
    a0 = 8'h33; b0 = 8'h44; sub0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    compared++;
    if ({busy0, done0, sum0, co0, ov0} !== 12'h000) begin
      mismatched++;
      $display("FAIL abort: got busy/done/sum/c/v=%h, want 000", {busy0, done0, sum0, co0, ov0});
    end
    repeat (6) @(negedge clk);
    issue0(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    wait_idle0();
  endtask

  task automatic rand1();
    for (int i = 0; i < 1000; i++) begin
      int unsigned k = 0;
      while (busy1 && k < 20) begin @(negedge clk); k++; end
      if (busy1) begin
        compared++; mismatched++;
        $display("FAIL idle1: busy=%b, want 0 within 20 cycles", busy1);
      end
      a1 = 8'($urandom); b1 = 8'($urandom);
      sub1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1)); start1 = 1'b1;
      q1.push_back(model(8, {8'h00, a1}, {8'h00, b1}, sub1, cin1, cyc + 2));
      @(negedge clk);
      start1 = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic rand2();
    for (int i = 0; i < 1000; i++) begin
      int unsigned k = 0;
      while (busy2 && k < 20) begin @(negedge clk); k++; end
      if (busy2) begin
        compared++; mismatched++;
        $display("FAIL idle2: busy=%b, want 0 within 20 cycles", busy2);
      end
      a2 = 16'($urandom); b2 = 16'($urandom);
      sub2 = 1'($urandom_range(0, 1)); cin2 = 1'($urandom_range(0, 1)); start2 = 1'b1;
      q2.push_back(model(16, a2, b2, sub2, cin2, cyc + 5));
      @(negedge clk);
      start2 = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_r = 1'b0;
    fork
      main_seq();
      rand1();
      rand2();
    join
    for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    compared++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d/%0d/%0d, want 0/0/0", q0.size(), q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_digit_adder.md
SERIAL_DIGIT_ADDER -- requirements
Module: serial_digit_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2, bits added per clock cycle.
REQ-003 The block SHALL require WIDTH % DIGIT == 0 and WIDTH >= DIGIT >= 1; N = WIDTH/DIGIT is the number of add cycles.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  request; operands are captured when accepted.
REQ-008 sub  input  1  0 = a + b + c_in, 1 = a - b (c_in ignored).
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 c_in  input  1  carry-in, add mode only.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse, results newly valid.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 c_out  output  1  carry out of the MSB; in sub mode 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE/DONE with start=1: capture a, (sub ? ~b : b) and initial carry (sub ? 1 : c_in); clear the digit counter; go to RUN.
REQ-019 IDLE/DONE with start=0: DONE goes to IDLE; IDLE holds.
REQ-020 RUN, each cycle: add the low DIGIT bits of the A and B registers plus the carry register; shift the DIGIT-bit result into the MSB end of the internal sum shift register; shift the operands right by DIGIT; store the carry; increment the counter.
REQ-021 RUN SHALL last exactly N cycles; after the N-th cycle, go to DONE.
REQ-022 On entry to DONE, sum, c_out and ovf SHALL be loaded together from the final internal state.
REQ-023 ovf SHALL equal (carry into MSB) XOR (carry out of MSB) of the final digit.
REQ-024 sum, c_out and ovf SHALL hold their values between completions; they SHALL NOT change during RUN.
REQ-025 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-026 Timing: start sampled at edge k gives busy=1 after edges k..k+N-1 and done=1 after edge k+N; latency is N cycles.
REQ-027 start, a, b, sub and c_in SHALL be ignored while in RUN.
REQ-028 start=1 in DONE SHALL be accepted (back-to-back), so done is a single-cycle pulse followed by busy.
REQ-029 For N=1, RUN SHALL last one cycle and all rules above still hold.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE and busy=0, done=0, sum=0, c_out=0, ovf=0; internal operand, carry and counter registers SHALL clear.
REQ-031 rst SHALL take priority over start and over any state, including mid-RUN.
REQ-032 An aborted operation SHALL produce no done pulse; the first edge with rst=0 SHALL accept start normally.

Verification (WIDTH=8, DIGIT=2, N=4 unless stated)
REQ-033 a=0xFF, b=0x01, c_in=0, sub=0 -> sum=0x00, c_out=1, ovf=0; busy for 4 cycles, then done for 1 cycle. a=0x0F, b=0x00, c_in=1 -> sum=0x10.
REQ-034 a=0x7F, b=0x01, add -> sum=0x80, c_out=0, ovf=1. sub with a=0x05, b=0x07 -> sum=0xFE, c_out=0, ovf=0. sub with a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.
REQ-035 start held high, operands changed during busy -> result matches the operands captured at acceptance; start=1 in the done cycle -> second result with done 4 cycles later, and outputs stable in between.
REQ-036 rst asserted in the 2nd busy cycle -> next cycle all outputs 0, busy=0, no done; a new start afterwards completes correctly.
REQ-037 Configurations WIDTH=8/DIGIT=8 and WIDTH=16/DIGIT=4 with 1000 random operands, sub and c_in -> sum, c_out, ovf and latency match a behavioural model.
